// File: rtl/cordic_req_sched.sv
// Round-robin scheduler sharing one pipelined CORDIC sin/cos datapath among N requesters.
// Define CORDIC_REQ_SCHED_PRIO_EN to give requester 0 fixed top priority over the others.
module cordic_req_sched #(
  parameter int W       = 12,
  parameter int N       = 4,
  parameter int LAT     = 13,
  parameter int MAX_OUT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N-1:0]     req_func,
  input  logic [N*2*W-1:0] req_a,
  output logic [N-1:0]     rsp_valid,
  output logic [W-1:0]     rsp_data,
  output logic             cordic_start,
  output logic             cordic_func,
  output logic [2*W-1:0]   cordic_a,
  input  logic             cordic_valid,
  input  logic [W-1:0]     cordic_f,
  input  logic             drain_req,
  input  logic             resume,
  output logic             halted,
  output logic             seq_err
);
  localparam int IDW = $clog2(N);
  localparam int AW  = 2 * W;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [IDW-1:0]          ptr_r, ptr_nxt_s, gnt_id_s, issue_id_r;
  logic                    gnt_s;
  logic [N-1:0]            elig_s, ready_s;
  logic [N-1:0][3:0]       cnt_r, cnt_nxt_s;
  logic                    cnt_uflow_s, cnt_idle_s;
  logic [LAT-1:0]          tag_v_r;
  logic [LAT-1:0][IDW-1:0] tag_id_r;
  logic                    tag_v_out_s;
  logic [IDW-1:0]          tag_id_out_s;
  logic                    rsp_fire_s, tag_err_s;
  logic [N-1:0]            rsp_valid_r;
  logic [W-1:0]            rsp_data_r;
  logic                    cordic_start_r, cordic_func_r;
  logic [AW-1:0]           cordic_a_r;
  logic                    halted_r, seq_err_r;

  assign tag_v_out_s  = tag_v_r[LAT-1];
  assign tag_id_out_s = tag_id_r[LAT-1];
  assign rsp_fire_s   = cordic_valid & tag_v_out_s;
  assign tag_err_s    = cordic_valid ^ tag_v_out_s;

  // Requesters that may be granted this cycle.
  always_comb begin
    elig_s = {N{1'b0}};
    for (int i = 32'sd0; i < N; i++) begin
      elig_s[i] = req_valid[i] && (cnt_r[i] < MAX_CNT) && (state_r == ST_ACTIVE) && !rst;
    end
  end

  // Arbiter: first eligible requester at or after the round-robin pointer.
  always_comb begin
    int  base;
    int  idx;
    logic hit;
    base      = 32'sd0;
    idx       = 32'sd0;
    hit       = 1'b0;
    gnt_s     = 1'b0;
    gnt_id_s  = {IDW{1'b0}};
    ptr_nxt_s = ptr_r;
`ifdef CORDIC_REQ_SCHED_PRIO_EN
    if (elig_s[0]) begin
      gnt_s = 1'b1;
    end else begin
      // Pointer lives in 1..N-1; a pointer of 0 (after reset) behaves as 1.
      base = (ptr_r == {IDW{1'b0}}) ? 32'sd0 : int'(ptr_r) - 32'sd1;
      for (int k = 32'sd0; k < N - 1; k++) begin
        idx       = 32'sd1 + (base + k) % (N - 1);
        hit       = !gnt_s && elig_s[IDW'(idx)];
        gnt_s     = gnt_s || hit;
        gnt_id_s  = hit ? IDW'(idx) : gnt_id_s;
        ptr_nxt_s = hit ? ((idx == N - 1) ? IDW'(32'sd1) : IDW'(idx + 32'sd1)) : ptr_nxt_s;
      end
    end
`else
    for (int k = 32'sd0; k < N; k++) begin
      idx       = (int'(ptr_r) + k) % N;
      hit       = !gnt_s && elig_s[IDW'(idx)];
      gnt_s     = gnt_s || hit;
      gnt_id_s  = hit ? IDW'(idx) : gnt_id_s;
      ptr_nxt_s = hit ? IDW'((idx + 32'sd1) % N) : ptr_nxt_s;
    end
`endif
    ready_s = gnt_s ? ({{(N-1){1'b0}}, 1'b1} << gnt_id_s) : {N{1'b0}};
  end

  assign req_ready = ready_s;

  // Outstanding counters: accept adds, response subtracts, never wrapping below zero.
  always_comb begin
    logic inc;
    logic dec;
    inc         = 1'b0;
    dec         = 1'b0;
    cnt_nxt_s   = cnt_r;
    cnt_uflow_s = 1'b0;
    cnt_idle_s  = 1'b1;
    for (int i = 32'sd0; i < N; i++) begin
      inc         = gnt_s && (gnt_id_s == IDW'(i));
      dec         = rsp_fire_s && (tag_id_out_s == IDW'(i));
      cnt_uflow_s = cnt_uflow_s || (dec && (cnt_r[i] == 4'd0));
      cnt_idle_s  = cnt_idle_s && (cnt_r[i] == 4'd0);
      case ({inc, dec && (cnt_r[i] != 4'd0)})
        2'b10:   cnt_nxt_s[i] = cnt_r[i] + 4'd1;
        2'b01:   cnt_nxt_s[i] = cnt_r[i] - 4'd1;
        default: cnt_nxt_s[i] = cnt_r[i];
      endcase
    end
  end

  // Drain/halt next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACTIVE: state_nxt_s = drain_req ? ST_DRAIN : ST_ACTIVE;
      ST_DRAIN:  state_nxt_s = (cnt_idle_s && !cordic_start_r) ? ST_HALTED : ST_DRAIN;
      ST_HALTED: state_nxt_s = resume ? ST_ACTIVE : ST_HALTED;
      default:   state_nxt_s = ST_ACTIVE;
    endcase
  end

  // Drain/halt state register and halted flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_ACTIVE;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      halted_r <= (state_nxt_s == ST_HALTED);
    end
  end

  // Issue registers, tag pipeline, response steering, counters and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r          <= {IDW{1'b0}};
      issue_id_r     <= {IDW{1'b0}};
      cordic_start_r <= 1'b0;
      cordic_func_r  <= 1'b0;
      cordic_a_r     <= {AW{1'b0}};
      tag_v_r        <= {LAT{1'b0}};
      tag_id_r       <= {(LAT*IDW){1'b0}};
      rsp_valid_r    <= {N{1'b0}};
      rsp_data_r     <= {W{1'b0}};
      cnt_r          <= {(N*4){1'b0}};
      seq_err_r      <= 1'b0;
    end else begin
      ptr_r          <= ptr_nxt_s;
      cordic_start_r <= gnt_s;
      if (gnt_s) begin
        cordic_func_r <= req_func[gnt_id_s];
        cordic_a_r    <= req_a[int'(gnt_id_s)*AW +: AW];
        issue_id_r    <= gnt_id_s;
      end
      // Stage 0 captures the strobe being driven now, so the last stage lines up with cordic_valid.
      tag_v_r[0]  <= cordic_start_r;
      tag_id_r[0] <= issue_id_r;
      for (int s = 32'sd1; s < LAT; s++) begin
        tag_v_r[s]  <= tag_v_r[s-1];
        tag_id_r[s] <= tag_id_r[s-1];
      end
      rsp_valid_r <= rsp_fire_s ? ({{(N-1){1'b0}}, 1'b1} << tag_id_out_s) : {N{1'b0}};
      if (rsp_fire_s) begin
        rsp_data_r <= cordic_f;
      end
      cnt_r     <= cnt_nxt_s;
      seq_err_r <= seq_err_r | tag_err_s | cnt_uflow_s;
    end
  end

  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign cordic_start = cordic_start_r;
  assign cordic_func  = cordic_func_r;
  assign cordic_a     = cordic_a_r;
  assign halted       = halted_r;
  assign seq_err      = seq_err_r;

endmodule

// File: tb/tb_cordic_req_sched.sv
// Bench for cordic_req_sched: datapath stand-in, in-flight-queue reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_cordic_req_sched;
  localparam int W = 12, N = 4, LAT = 13, MAX_OUT = 3;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, req_func, rsp_valid;
  logic [N*2*W-1:0] req_a;
  logic [W-1:0]     rsp_data, cordic_f;
  logic             cordic_start, cordic_func, cordic_valid;
  logic [2*W-1:0]   cordic_a;
  logic             drain_req, resume, halted, seq_err;

  cordic_req_sched #(.W(W), .N(N), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_a(req_a), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cordic_start(cordic_start), .cordic_func(cordic_func), .cordic_a(cordic_a),
    .cordic_valid(cordic_valid), .cordic_f(cordic_f), .drain_req(drain_req),
    .resume(resume), .halted(halted), .seq_err(seq_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Datapath stand-in: a result scheduled LAT cycles after each observed cordic_start.
  int             cyc = 0;
  bit             sv [64];
  logic [W-1:0]   sf [64];
  logic           inj = 1'b0;

  initial begin
    cordic_valid = 1'b0;
    cordic_f     = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      cordic_valid = sv[cyc % 64] | inj;
      cordic_f     = sv[cyc % 64] ? sf[cyc % 64] : '0;
    end
  end

  // Reference model: per-requester counts, pointer, mode, and a queue of ops with due cycles.
  typedef struct packed { int id; int due; } op_t;
  op_t            fifo[$];
  int             m_cnt [N];
  int             m_ptr;
  int             m_st;    // 0 active, 1 draining, 2 halted
  logic           e_start, e_func, e_halt, e_seq;
  logic [2*W-1:0] e_a;
  logic [N-1:0]   e_rv;
  logic [W-1:0]   e_rd;
  bit             armed = 0;

  function automatic bit elig(input int i);
    return req_valid[i] && (m_cnt[i] < MAX_OUT) && (m_st == 0);
  endfunction

  function automatic int pick();
`ifdef CORDIC_REQ_SCHED_PRIO_EN
    if (elig(0)) return 0;
    for (int k = 0; k < N - 1; k++) begin
      int i;
      i = 1 + (((m_ptr == 0) ? 0 : m_ptr - 1) + k) % (N - 1);
      if (elig(i)) return i;
    end
`else
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (elig(i)) return i;
    end
`endif
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    int rid;
    bit due;
    bit idle;
    logic [N-1:0] exp_ready;
    if (armed) begin
      chk("cordic_start", cordic_start, e_start);
      chk("cordic_func", cordic_func, e_func);
      chk("cordic_a", cordic_a, e_a);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv != '0) chk("rsp_data", rsp_data, e_rd);
      chk("halted", halted, e_halt);
      chk("seq_err", seq_err, e_seq);
    end
    g = rst ? -1 : pick();
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    if (armed || rst) chk("req_ready", req_ready, exp_ready);
    if (rst) begin
      fifo.delete();
      foreach (sv[i]) sv[i] = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ptr = 0; m_st = 0;
      e_start = 0; e_func = 0; e_halt = 0; e_seq = 0; e_a = '0; e_rv = '0; e_rd = '0;
      armed = 1;
    end else begin
      sv[cyc % 64] = 0;
      if (cordic_start) begin
        sv[(cyc + LAT) % 64] = 1;
        sf[(cyc + LAT) % 64] = cordic_a[W-1:0] ^ {W{cordic_func}};
      end
      idle = !e_start;
      foreach (m_cnt[i]) if (m_cnt[i] != 0) idle = 0;
      due = (fifo.size() > 0) && (fifo[0].due == cyc);
      if (cordic_valid != due) e_seq = 1;
      rid = -1;
      if (due) begin
        rid = fifo[0].id;
        void'(fifo.pop_front());
      end
      e_rv = '0;
      if (due && cordic_valid) begin
        e_rv = N'(1) << rid;
        e_rd = cordic_f;
        if (m_cnt[rid] == 0) e_seq = 1;
        else m_cnt[rid]--;
      end
      e_start = (g >= 0);
      if (g >= 0) begin
        m_cnt[g]++;
        fifo.push_back('{g, cyc + 1 + LAT});
        e_func = req_func[g];
        e_a    = req_a[g*2*W +: 2*W];
`ifdef CORDIC_REQ_SCHED_PRIO_EN
        if (g != 0) m_ptr = (g == N - 1) ? 1 : g + 1;
`else
        m_ptr = (g + 1) % N;
`endif
      end
      case (m_st)
        0: if (drain_req) m_st = 1;
        1: if (idle) m_st = 2;
        2: if (resume) m_st = 0;
        default: m_st = 0;
      endcase
      e_halt = (m_st == 2);
    end
  end

  task automatic do_reset();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
  endtask

  initial begin
    int gseq [8];
    int rcnt [N];
    int acc, lastr, hcyc;
    rst = 1'b1; req_valid = '0; req_func = '0; req_a = '0; drain_req = 1'b0; resume = 1'b0;
    repeat (3) step();
    rst = 1'b0; #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_start", cordic_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cordic_a", cordic_a, 0);
    chk("rst_halted", halted, 0);
    chk("rst_seq_err", seq_err, 0);

    // Single request on requester 0.
    step(); req_valid = 4'b0001; req_func = 4'b0001; req_a[23:0] = 24'h000C90; #2;
    chk("single_ready", req_ready, 4'b0001);
    step(); req_valid = '0; #2;
    chk("single_start", cordic_start, 1);
    chk("single_func", cordic_func, 1);
    chk("single_a", cordic_a, 24'h000C90);
    repeat (LAT) step();
    step(); #2;
    chk("single_rsp_valid", rsp_valid, 4'b0001);
    chk("single_rsp_data", rsp_data, 12'h36F);
    chk("single_seq_err", seq_err, 0);

    // Fairness from a fresh pointer.
    do_reset();
    foreach (rcnt[i]) rcnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      step(); req_valid = 4'hF; req_func = 4'($urandom); req_a = {$urandom, $urandom, $urandom}; #2;
      gseq[k] = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) gseq[k] = i;
    end
    step(); req_valid = '0;
    for (int k = 0; k < LAT + 12; k++) begin
      #2;
      for (int i = 0; i < N; i++) if (rsp_valid[i]) rcnt[i]++;
      step();
    end
`ifndef CORDIC_REQ_SCHED_PRIO_EN
    for (int k = 0; k < 8; k++) chk("fair_grant_order", gseq[k], k % N);
`endif
    for (int i = 0; i < N; i++) chk("fair_rsp_count", rcnt[i], 2);

    // Outstanding limit on requester 2.
    acc = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      step(); req_valid = 4'b0100; #2;
      acc += int'(req_ready[2]);
    end
    chk("limit_accepts", acc, MAX_OUT);
    step(); #2;
    chk("limit_reaccept", req_ready, 4'b0100);
    step(); req_valid = '0;
    repeat (LAT + 6) step();

    // Drain with five ops in flight; the last accept coincides with drain_req.
    repeat (4) begin step(); req_valid = 4'hF; end
    step(); req_valid = 4'hF; drain_req = 1'b1;
    lastr = -1; hcyc = -1;
    for (int k = 0; k < 40 && hcyc < 0; k++) begin
      step(); drain_req = 1'b0; #2;
      if (halted) hcyc = k;
      else begin
        chk("drain_no_ready", req_ready, 0);
        if (rsp_valid != '0) lastr = k;
      end
    end
    chk("halt_after_last_rsp", hcyc - lastr, 1);
    step(); resume = 1'b1; #2;
    chk("halted_before_resume", halted, 1);
    step(); resume = 1'b0; #2;
    chk("resume_grant", req_ready != '0, 1);
    chk("resume_halted", halted, 0);
    step(); req_valid = '0;
    repeat (LAT + 10) step();

    // Stray datapath valid with nothing in flight.
    step(); inj = 1'b1;
    step(); inj = 1'b0; #2;
    chk("err_seq_err", seq_err, 1);
    chk("err_no_rsp", rsp_valid, 0);
    repeat (5) step();
    #2;
    chk("err_sticky", seq_err, 1);

    // Reset with four ops in flight.
    repeat (4) begin step(); req_valid = 4'hF; end
    step(); req_valid = '0; rst = 1'b1;
    step(); rst = 1'b0; #2;
    chk("midrst_start", cordic_start, 0);
    chk("midrst_a", cordic_a, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_seq_err", seq_err, 0);
    step(); req_valid = 4'b0001; #2;
    chk("midrst_reissue", req_ready, 4'b0001);
    step(); req_valid = '0;

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step();
      req_valid = 4'($urandom);
      req_func  = 4'($urandom);
      req_a     = {$urandom, $urandom, $urandom};
      drain_req = ($urandom_range(0, 39) == 0);
      resume    = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 399) == 0);
    end
    step(); req_valid = '0; drain_req = 1'b0; resume = 1'b0; rst = 1'b0;
    repeat (LAT + 10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/cordic_req_sched.md
Name: cordic_req_sched

Overview:
- Shares one pipelined circular-mode CORDIC sine/cosine datapath among N requesters.
- Round-robin arbitration issues at most one operation per cycle into the datapath.
- The requester ID travels through a tag pipeline matched to the datapath latency, so each result is steered back to its owner.
- Per-requester outstanding limits, plus a drain/halt state machine so software can quiesce the datapath before reconfiguring or resetting it.

Parameters:
- W, 12, datapath result width; operand width is 2*W.
- N, 4, number of requesters (2..8); IDW = clog2(N) is a derived localparam.
- LAT, 13, cycles from cordic_start high to the matching cordic_valid high.
- MAX_OUT, 3, maximum operations in flight per requester (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N  request valid, one bit per requester.
- req_ready  out  N  request accepted this cycle; one-hot or zero.
- req_func  in  N  function per requester: 0 = cos, 1 = sin.
- req_a  in  N*2*W  angle per requester; requester i uses bits [2W*(i+1)-1 : 2W*i].
- rsp_valid  out  N  one-hot response strobe.
- rsp_data  out  W  result for the requester flagged on rsp_valid.
- cordic_start  out  1  issue strobe to the datapath.
- cordic_func  out  1  function to the datapath.
- cordic_a  out  2*W  angle to the datapath.
- cordic_valid  in  1  datapath output valid.
- cordic_f  in  W  datapath result.
- drain_req  in  1  pulse: stop granting and drain the datapath.
- resume  in  1  pulse: leave HALTED.
- halted  out  1  high while in HALTED.
- seq_err  out  1  sticky tag/valid mismatch flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - req_ready, rsp_valid, cordic_start, cordic_func, halted, seq_err = 0.
  - rsp_data, cordic_a = 0.
  - Tag pipeline cleared; all outstanding counters = 0.
  - Round-robin pointer = 0; state = ACTIVE.
  - Reset mid-operation discards in-flight tags. Any cordic_valid arriving after reset with an empty tag slot sets seq_err; the integrator also resets the datapath.
- Eligibility: requester i is eligible when req_valid[i] is high, cnt[i] < MAX_OUT and state is ACTIVE.
- Arbitration: round-robin starting at the pointer. req_ready is combinational, one-hot among eligible requesters. On a grant to requester g, the pointer becomes (g+1) mod N.
- Issue:
  - Acceptance happens in cycle T. In cycle T+1: cordic_start=1, cordic_func and cordic_a = the granted requester's inputs.
  - Otherwise cordic_start=0 and cordic_func/cordic_a hold their last values.
- Tag pipeline:
  - LAT-stage shift register of {valid, id}.
  - Stage 0 loads {cordic_start, granted id} in the same cycle cordic_start is driven.
- Response:
  - When cordic_valid=1, the cycle after it: rsp_valid[id]=1 and rsp_data=cordic_f, with id taken from the final tag stage.
  - If cordic_valid differs from the final tag valid bit: seq_err=1 (sticky until rst) and no rsp_valid is raised.
  - Responses have no backpressure.
- Outstanding counters:
  - cnt[i] increments on accept and decrements on response.
  - Simultaneous accept and response for the same requester leaves cnt[i] unchanged.
  - Counters never wrap: accept is blocked at MAX_OUT; a response at 0 sets seq_err.
- State machine:
  - ACTIVE: drain_req goes to DRAIN.
  - DRAIN: no grants. When all cnt are 0 and cordic_start=0, go to HALTED; halted=1 from the next cycle.
  - HALTED: no grants. resume goes to ACTIVE; halted=0 next cycle.
  - drain_req in DRAIN or HALTED is ignored. resume outside HALTED is ignored.
  - drain_req together with a grant in the same cycle: the grant completes, then DRAIN.
- Throughput: one accept per cycle sustained. Per-requester rate is limited to MAX_OUT per LAT+2 cycles.

Optional Feature:
- Macro CORDIC_REQ_SCHED_PRIO_EN.
- Defined: requester 0 has fixed highest priority. Requesters 1..N-1 share the remaining grants round-robin; the pointer skips 0.
- Undefined: pure round-robin over all N requesters, exactly as in Behaviour.

Test Plan:
- Single request: rst, then req_valid=0001, req_func=1, req_a0=24'h000C90 (≈π/4) -> req_ready=0001 at cycle T; cordic_start at T+1; rsp_valid=0001 at T+LAT+2 with rsp_data=cordic_f; seq_err=0.
- Fairness: req_valid=1111 held for 8 cycles, datapath model returns results -> grant order 0,1,2,3,0,1,2,3; each requester gets exactly 2 responses, in issue order.
- Outstanding limit: only requester 2 valid, continuously; datapath model with LAT=13 -> exactly 3 accepts, req_ready[2]=0 until the first response. After that response, a new accept and cnt[2]=3 again.
- Drain: 5 operations in flight, pulse drain_req -> no req_ready while draining; halted=1 one cycle after the last response. resume pulse -> grants restart next cycle.
- Error: force cordic_valid=1 with an empty tag pipeline -> seq_err=1 and stays 1 until rst; no rsp_valid raised.
- Reset mid-operation: assert rst with 4 operations in flight -> all outputs 0 and counters cleared next cycle; normal issue resumes after rst deasserts.
